// File: rtl/snow_fall_engine.sv
// snow_fall_engine: per-frame snow physics sweep over a 1-bit screen RAM.
// Falls flakes one row, piles them on the bottom row, respawns row 0 from an LFSR.
module snow_fall_engine #(
    parameter int          XBITS     = 8,
    parameter int          YBITS     = 8,
    parameter int          FRAME_DIV = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk_pix,
    input  logic                   rst_pix_n,
    input  logic                   frame_start,
    input  logic                   enable,
    input  logic [7:0]             density,
    output logic [XBITS+YBITS-1:0] mem_rd_addr,
    input  logic                   mem_rd_data,
    output logic                   mem_we,
    output logic [XBITS+YBITS-1:0] mem_wr_addr,
    output logic                   mem_wr_data,
    output logic                   busy,
    output logic                   sweep_done,
    output logic                   overrun
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(FRAME_DIV - 1);
    localparam logic [XBITS-1:0] X_LAST   = '1;
    localparam logic [YBITS-1:0] Y_LAST   = '1;
    localparam logic [YBITS-1:0] Y_PEN    = Y_LAST - YBITS'(1);
    localparam logic [YBITS-1:0] Y_ONE    = YBITS'(1);
    localparam logic [15:0]      TAPS     = 16'b1101000000001000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOT_A,
        S_BOT_B,
        S_BOT_W,
        S_SHIFT,
        S_SPAWN,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [XBITS-1:0]         r_x;
    logic [YBITS-1:0]         r_y;
    logic [CW-1:0]            r_frame_cnt;
    logic [15:0]              r_lfsr;
    logic [7:0]               r_density;
    logic                     r_old;
    logic                     r_pv;
    logic                     r_drain;
    logic                     r_overrun;
    logic [XBITS+YBITS-1:0]   r_wr_addr;

    logic                     w_count;
    logic                     w_trig;
    logic [15:0]              w_lfsr_next;
    logic [YBITS-1:0]         w_y_up;

    assign w_count     = frame_start && enable && (r_state == S_IDLE);
    assign w_trig      = w_count && (r_frame_cnt == CNT_LAST);
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
    assign w_y_up      = r_y - YBITS'(1);

    // State register
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_trig) w_next = S_BOT_A;
            S_BOT_A: w_next = S_BOT_B;
            S_BOT_B: w_next = S_BOT_W;
            S_BOT_W: w_next = (r_x == X_LAST) ? S_SHIFT : S_BOT_A;
            S_SHIFT: if (r_drain) w_next = S_SPAWN;
            S_SPAWN: if (r_x == X_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Counters, pipeline registers, LFSR and sticky flags
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
            r_lfsr      <= LFSR_SEED;
            r_density   <= '0;
            r_old       <= 1'b0;
            r_pv        <= 1'b0;
            r_drain     <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            if (frame_start && enable && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            if (w_count)
                r_frame_cnt <= w_trig ? '0 : r_frame_cnt + CW'(1);
            if (w_trig)
                r_density <= density;
            unique case (r_state)
                S_BOT_B: r_old <= mem_rd_data;
                S_BOT_W: begin
                    r_x <= r_x + XBITS'(1);
                    if (r_x == X_LAST) begin
                        r_y     <= Y_PEN;
                        r_pv    <= 1'b0;
                        r_drain <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_drain) begin
                        r_pv    <= 1'b0;
                        r_drain <= 1'b0;
                    end else begin
                        r_wr_addr <= {r_y, r_x};
                        r_pv      <= 1'b1;
                        r_x       <= r_x + XBITS'(1);
                        if (r_x == X_LAST) begin
                            r_y <= w_y_up;
                            if (r_y == Y_ONE)
                                r_drain <= 1'b1;
                        end
                    end
                end
                S_SPAWN: begin
                    r_lfsr <= w_lfsr_next;
                    r_x    <= r_x + XBITS'(1);
                end
                S_DONE: begin
                    r_x <= '0;
                    r_y <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode from state and counters
    always_comb begin
        mem_rd_addr = '0;
        mem_we      = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = 1'b0;
        busy        = (r_state != S_IDLE);
        sweep_done  = (r_state == S_DONE);
        overrun     = r_overrun;
        unique case (r_state)
            S_BOT_A: mem_rd_addr = {Y_LAST, r_x};
            S_BOT_B: mem_rd_addr = {Y_PEN, r_x};
            S_BOT_W: begin
                mem_we      = 1'b1;
                mem_wr_addr = {Y_LAST, r_x};
                mem_wr_data = r_old | mem_rd_data;
            end
            S_SHIFT: begin
                if (!r_drain)
                    mem_rd_addr = {w_y_up, r_x};
                mem_we      = r_pv;
                mem_wr_addr = r_wr_addr;
                mem_wr_data = r_pv & mem_rd_data;
            end
            S_SPAWN: begin
                mem_we      = 1'b1;
                mem_wr_addr = {YBITS'(0), r_x};
                mem_wr_data = (r_lfsr[7:0] < r_density);
            end
            default: ;
        endcase
    end

endmodule
